interrupt_controller: RTL and testbench
=======================================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter VECTOR_BASE, default 8'h40, base of the returned vector; vector = VECTOR_BASE + level, modulo 256.
REQ-002 Ports (one clock; reset is asynchronous and active-low):
- clock  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous active-low reset.
- irq_in  input  8  interrupt sources; already synchronized to clock; bit 7 highest priority.
- wr_en  input  1  host register write strobe, one cycle.
- addr  input  2  register select for write and read.
- wr_data  input  8  host write data.
- rd_data  output  8  combinational register read data.
- int_n  output  1  active-low interrupt request to CPU.
- iack  input  1  CPU acknowledge; held high until the vector is taken.
- vector  output  8  acknowledged vector.
- vector_valid  output  1  vector is valid.

Function
REQ-003 Registers:
- addr 0: mask R/W; 1 = source enabled.
- addr 1: pending read; write-1-to-clear.
- addr 2: writing 1s sets pending (software trigger); read returns pending & mask.
- addr 3: read-only status {in_service, 4'b0, level[2:0]}; writes are ignored.
REQ-004 Source capture:
- Edge mode: a rising edge (previous sample 0, current sample 1) sets pending[i] at the next rising clock edge.
- Level mode: pending[i] is set on every cycle in which irq_in[i]=1.
REQ-005 Pending updates in the same cycle for the same bit resolve as: hardware set > software set > W1C or acknowledge clear. The set always wins.
REQ-006 Active set = pending & mask.
- Resolved level = index of its highest set bit.
- Resolution is combinational from registered state.
REQ-007 FSM states IDLE, REQ, ACK.
- Reset state is IDLE.
- int_n=0 only in REQ and ACK.
REQ-008 IDLE -> REQ when the active set is nonzero. int_n falls one cycle after the pending bit is registered.
REQ-009 REQ with iack=1 -> ACK. On that edge:
- latch level;
- vector <= VECTOR_BASE + level;
- vector_valid <= 1;
- in_service <= 1;
- clear pending[level].
REQ-010 REQ with iack=0 and an empty active set (masked or cleared) -> IDLE. int_n returns high the next cycle and no vector is issued.
REQ-011 ACK holds vector and vector_valid until iack=0, then -> IDLE. On that transition: vector_valid <= 0, in_service <= 0, vector keeps its last value.
REQ-012 iack=1 while in IDLE is ignored; no state change.
REQ-013 Level latch is stable across ACK. Higher-priority arrivals during ACK stay pending and are serviced after the return to IDLE, with a minimum of one cycle in IDLE.
REQ-014 Acknowledge latency: vector_valid=1 on the first edge after iack is sampled high in REQ.

Reset
REQ-015 reset_n=0 asynchronously clears mask, pending, edge history, the level latch, in_service and the FSM (IDLE). Resulting outputs: int_n=1, vector=8'h00, vector_valid=0.
REQ-016 Reset mid-handshake, including during ACK, abandons the cycle. After release, no interrupt is asserted until a new capture event occurs.

Configuration
REQ-017 Macro INTC_EDGE_DETECT_EN:
- Defined: edge mode per REQ-004, using a one-register-per-bit history.
- Undefined: level mode per REQ-004 and no history register. Pending still requires W1C or acknowledge to clear and re-sets while the input is high.

Verification
REQ-018 Edge mode. mask=8'hFF, pulse irq_in[3] for 1 cycle -> int_n low; raise iack -> next cycle vector=8'h43 and vector_valid=1; drop iack -> int_n=1 and pending=8'h00.
REQ-019 mask=8'hFF, irq_in[1] and irq_in[6] rise in the same cycle -> first vector 8'h46, second vector 8'h41 after the second handshake.
REQ-020 mask=8'h00 with an irq_in[2] edge -> int_n stays 1 and addr1 reads 8'h04; then write mask=8'h04 -> int_n falls.
REQ-021 In REQ, write addr1=8'h10 clearing the only pending bit 4 -> int_n returns 1 and no vector is issued; on a same-cycle W1C and a new edge on bit 4 -> pending[4] stays 1.
REQ-022 Assert reset_n=0 during ACK -> int_n=1, vector_valid=0 and vector=8'h00 immediately; after release -> no request.
REQ-023 Level mode (macro undefined). Hold irq_in[0]=1 through the acknowledge -> pending[0] re-sets and a second request follows.

Source files
------------

// File: rtl/interrupt_controller_if.sv
// interrupt_controller_if: host register bus, interrupt sources and CPU vector handshake
interface interrupt_controller_if;
  logic [7:0] irq_in;
  logic       wr_en;
  logic [1:0] addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       int_n;
  logic       iack;
  logic [7:0] vector;
  logic       vector_valid;
  modport master (output irq_in, wr_en, addr, wr_data, iack, input rd_data, int_n, vector, vector_valid);
  modport slave (input irq_in, wr_en, addr, wr_data, iack, output rd_data, int_n, vector, vector_valid);
endinterface

// File: rtl/interrupt_controller.sv
// interrupt_controller: 8-source priority interrupt controller; define INTC_EDGE_DETECT_EN for edge capture (level capture otherwise)
module interrupt_controller #(
  parameter logic [7:0] VECTOR_BASE = 8'h40
) (
  input logic clock,
  input logic reset_n,
  interrupt_controller_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;
  state_t state, state_nx;
  logic [7:0] mask, pending, pending_nx, active, hw_set, sw_set, clr;
  logic [7:0] vector_q;
  logic [2:0] level, level_q;
  logic in_service, valid_q, ack_take;
`ifdef INTC_EDGE_DETECT_EN
  logic [7:0] irq_prev;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) irq_prev <= '0;
    else irq_prev <= bus.irq_in;
  assign hw_set = bus.irq_in & ~irq_prev;
`else
  assign hw_set = bus.irq_in;
`endif
  assign active = pending & mask;
  always_comb begin
    level = 3'd0;
    for (int i = 0; i < 8; i++) if (active[i]) level = 3'(i);
  end
  // an acknowledge with nothing left to service falls back to IDLE instead of issuing a vector
  assign ack_take = state == REQ && bus.iack && |active;
  assign sw_set = bus.wr_en && bus.addr == 2'd2 ? bus.wr_data : 8'h00;
  assign clr = (bus.wr_en && bus.addr == 2'd1 ? bus.wr_data : 8'h00) | (ack_take ? 8'h01 << level : 8'h00);
  assign pending_nx = (pending & ~clr) | sw_set | hw_set;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = |active ? REQ : IDLE;
      REQ: state_nx = !(|active) ? IDLE : bus.iack ? ACK : REQ;
      ACK: state_nx = bus.iack ? ACK : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      mask <= '0;
      pending <= '0;
      level_q <= '0;
      in_service <= 1'b0;
      vector_q <= '0;
      valid_q <= 1'b0;
    end else begin
      pending <= pending_nx;
      if (bus.wr_en && bus.addr == 2'd0) mask <= bus.wr_data;
      if (ack_take) begin
        level_q <= level;
        vector_q <= VECTOR_BASE + {5'd0, level};
        valid_q <= 1'b1;
        in_service <= 1'b1;
      end else if (state == ACK && !bus.iack) begin
        valid_q <= 1'b0;
        in_service <= 1'b0;
      end
    end
  assign bus.rd_data = bus.addr == 2'd0 ? mask :
                       bus.addr == 2'd1 ? pending :
                       bus.addr == 2'd2 ? active : {in_service, 4'b0000, level_q};
  assign bus.int_n = state == IDLE;
  assign bus.vector = vector_q;
  assign bus.vector_valid = valid_q;
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed and random stimulus against a cycle-level behavioural model
module tb_interrupt_controller;
`ifdef INTC_EDGE_DETECT_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif
  localparam logic [7:0] VB = 8'h40;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  interrupt_controller_if bus();
  interrupt_controller #(.VECTOR_BASE(VB)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;
  // model: phase 0 idle, 1 requesting, 2 acknowledged
  logic [7:0] m_mask, m_pend, m_prev, m_vec;
  logic [2:0] m_lvl;
  logic m_vv, m_is;
  int m_ph;
  function automatic int top_bit(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction
  function automatic logic [7:0] exp_rd(input logic [1:0] a);
    case (a)
      2'd0: return m_mask;
      2'd1: return m_pend;
      2'd2: return m_pend & m_mask;
      default: return {m_is, 4'b0000, m_lvl};
    endcase
  endfunction
  task automatic model_reset();
    m_mask = 0; m_pend = 0; m_prev = 0; m_vec = 0; m_lvl = 0; m_vv = 0; m_is = 0; m_ph = 0;
  endtask
  task automatic model_step(input logic [7:0] irq, input logic we, input logic [1:0] a, input logic [7:0] wd, input logic ack);
    logic [7:0] act, clr, set;
    int lvl;
    act = m_pend & m_mask;
    lvl = top_bit(act);
    set = (EDGE ? irq & ~m_prev : irq) | ((we && a == 2'd2) ? wd : 8'h00);
    clr = (we && a == 2'd1) ? wd : 8'h00;
    if (m_ph == 1 && act != 0 && ack) begin
      clr[lvl] = 1'b1;
      m_lvl = 3'(lvl);
      m_vec = 8'(int'(VB) + lvl);
      m_vv = 1; m_is = 1; m_ph = 2;
    end else if (m_ph == 1 && act == 0) m_ph = 0;
    else if (m_ph == 2 && !ack) begin
      m_vv = 0; m_is = 0; m_ph = 0;
    end else if (m_ph == 0 && act != 0) m_ph = 1;
    m_pend = (m_pend & ~clr) | set;
    if (we && a == 2'd0) m_mask = wd;
    m_prev = irq;
  endtask
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic compare_all(input string tag);
    check({tag, "_int_n"}, {7'd0, bus.int_n}, {7'd0, m_ph == 0});
    check({tag, "_vv"}, {7'd0, bus.vector_valid}, {7'd0, m_vv});
    check({tag, "_vector"}, bus.vector, m_vec);
    check({tag, "_rd"}, bus.rd_data, exp_rd(bus.addr));
  endtask
  task automatic cyc(input string tag, input logic [7:0] irq, input logic we, input logic [1:0] a, input logic [7:0] wd, input logic ack);
    @(negedge clock);
    bus.irq_in = irq; bus.wr_en = we; bus.addr = a; bus.wr_data = wd; bus.iack = ack;
    @(posedge clock);
    model_step(irq, we, a, wd, ack);
    #1 compare_all(tag);
  endtask
  task automatic handshake(input string tag, input logic [7:0] exp_vec);
    cyc(tag, 8'h00, 1'b0, 2'd3, 8'h00, 1'b1);
    check({tag, "_vec_const"}, bus.vector, exp_vec);
    check({tag, "_vv_const"}, {7'd0, bus.vector_valid}, 8'h01);
    cyc(tag, 8'h00, 1'b0, 2'd1, 8'h00, 1'b0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    logic [7:0] r;
    bus.irq_in = 0; bus.wr_en = 0; bus.addr = 0; bus.wr_data = 0; bus.iack = 0;
    model_reset();
    #1 compare_all("reset");
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
    // single source, full handshake
    cyc("mask", 8'h00, 1'b1, 2'd0, 8'hFF, 1'b0);
    cyc("irq3", 8'h08, 1'b0, 2'd1, 8'h00, 1'b0);
    cyc("req3", 8'h00, 1'b0, 2'd1, 8'h00, 1'b0);
    check("req3_low", {7'd0, bus.int_n}, 8'h00);
    handshake("ack3", 8'h43);
    check("ack3_pend", bus.rd_data, 8'h00);
    check("ack3_int_n", {7'd0, bus.int_n}, 8'h01);
    // two simultaneous sources: priority order
    cyc("irq16", 8'h42, 1'b0, 2'd2, 8'h00, 1'b0);
    cyc("req16", 8'h00, 1'b0, 2'd2, 8'h00, 1'b0);
    handshake("ack6", 8'h46);
    cyc("idle1", 8'h00, 1'b0, 2'd3, 8'h00, 1'b0);
    handshake("ack1", 8'h41);
    // masked source stays pending until enabled
    cyc("mask0", 8'h00, 1'b1, 2'd0, 8'h00, 1'b0);
    cyc("irq2", 8'h04, 1'b0, 2'd1, 8'h00, 1'b0);
    cyc("masked", 8'h00, 1'b0, 2'd1, 8'h00, 1'b0);
    check("masked_pend", bus.rd_data, 8'h04);
    check("masked_int_n", {7'd0, bus.int_n}, 8'h01);
    cyc("unmask", 8'h00, 1'b1, 2'd0, 8'h04, 1'b0);
    cyc("unmasked", 8'h00, 1'b0, 2'd0, 8'h00, 1'b0);
    check("unmask_int_n", {7'd0, bus.int_n}, 8'h00);
    handshake("ack2", 8'h42);
    // W1C withdraws a request; set beats clear
    cyc("mask_ff", 8'h00, 1'b1, 2'd0, 8'hFF, 1'b0);
    cyc("irq4", 8'h10, 1'b0, 2'd1, 8'h00, 1'b0);
    cyc("req4", 8'h00, 1'b0, 2'd1, 8'h00, 1'b0);
    cyc("w1c4", 8'h00, 1'b1, 2'd1, 8'h10, 1'b0);
    cyc("drop4", 8'h00, 1'b0, 2'd1, 8'h00, 1'b0);
    check("drop4_int_n", {7'd0, bus.int_n}, 8'h01);
    check("drop4_vv", {7'd0, bus.vector_valid}, 8'h00);
    cyc("irq4b", 8'h10, 1'b0, 2'd1, 8'h00, 1'b0);
    cyc("gap4", 8'h00, 1'b0, 2'd1, 8'h00, 1'b0);
    cyc("w1c_set4", 8'h10, 1'b1, 2'd1, 8'h10, 1'b0);
    check("w1c_set4_pend", bus.rd_data, 8'h10);
    handshake("ack4", 8'h44);
    // asynchronous reset during ACK
    cyc("irq5", 8'h20, 1'b0, 2'd0, 8'h00, 1'b0);
    cyc("req5", 8'h00, 1'b0, 2'd0, 8'h00, 1'b0);
    cyc("ack5", 8'h00, 1'b0, 2'd0, 8'h00, 1'b1);
    #2 reset_n = 1'b0;
    model_reset();
    #1 compare_all("rst_ack");
    check("rst_vec", bus.vector, 8'h00);
    check("rst_int_n", {7'd0, bus.int_n}, 8'h01);
    bus.irq_in = 0; bus.wr_en = 0; bus.addr = 0; bus.wr_data = 0; bus.iack = 0;
    @(posedge clock);
    #2 reset_n = 1'b1;
    repeat (3) cyc("post_rst", 8'h00, 1'b0, 2'd1, 8'h00, 1'b0);
    check("post_rst_int_n", {7'd0, bus.int_n}, 8'h01);
    // held input through acknowledge
    cyc("mask_ff2", 8'h00, 1'b1, 2'd0, 8'hFF, 1'b0);
    cyc("hold0", 8'h01, 1'b0, 2'd1, 8'h00, 1'b0);
    cyc("hold0", 8'h01, 1'b0, 2'd1, 8'h00, 1'b0);
    cyc("hold0_ack", 8'h01, 1'b0, 2'd1, 8'h00, 1'b1);
    check("hold0_vec", bus.vector, 8'h40);
    cyc("hold0_rel", 8'h01, 1'b0, 2'd1, 8'h00, 1'b0);
    cyc("hold0_again", 8'h01, 1'b0, 2'd1, 8'h00, 1'b0);
    check("hold0_rereq", {7'd0, bus.int_n}, {7'd0, EDGE});
    cyc("hold0_drop", 8'h00, 1'b0, 2'd1, 8'h00, 1'b0);
    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      r = 8'($urandom);
      cyc("rand", 8'($urandom & $urandom & $urandom), r[0] & r[1] & r[2], 2'($urandom), 8'($urandom), r[5] | r[6]);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
